// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin arbiter sharing one signed 32/8 divider among N_REQ requesters
// Ports: Clk clock; Rst sync active-low reset; req per-requester request level;
//        dividend/divisor packed per-requester operands; gnt/done one-hot one-cycle pulses;
//        quot/dz shared result and divide-by-zero flag, held between done pulses; busy FSM not idle.
module div_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int LAT = 3
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*32-1:0]  dividend,
    input  logic [N_REQ*8-1:0]   divisor,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [7:0]           quot,
    output logic                 dz,
    output logic                 busy
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    localparam int PW = $clog2(N_REQ);
    logic [1:0]    state;
    logic [PW-1:0] ptr, win, pick;
    logic [3:0]    cnt;
    logic [31:0]   a;
    logic [7:0]    b, q8;
    // The first requester found searching upward from ptr wins; only used when |req.
    always_comb begin
        pick = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            int k;
            k = (int'(ptr) + i) % N_REQ;
            if (req[k]) pick = PW'(k);
        end
    end
    // 33-bit operands keep -2^31 / -1 representable before wrapping to 8 bits.
    assign q8 = 8'($signed({a[31], a}) / $signed({{25{b[7]}}, b}));
    assign busy = state != IDLE;
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state <= IDLE;
            ptr <= '0;
            win <= '0;
            cnt <= '0;
            a <= '0;
            b <= '0;
            gnt <= '0;
            done <= '0;
            quot <= '0;
            dz <= 1'b0;
        end else begin
            gnt <= '0;
            done <= '0;
            case (state)
                IDLE: if (|req) begin
                    win <= pick;
                    a <= dividend[32*pick +: 32];
                    b <= divisor[8*pick +: 8];
                    cnt <= 4'(LAT - 1);
                    gnt <= N_REQ'(1) << pick;
                    ptr <= PW'((int'(pick) + 1) % N_REQ);
                    state <= BUSY;
                end
                BUSY: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                else begin
                    quot <= b == 8'd0 ? 8'd0 : q8;
                    dz <= b == 8'd0;
                    done <= N_REQ'(1) << win;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/div_share_arbiter.md
DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing the divider (legal range 2..8).
REQ-002 Parameter LAT, default 3, SHALL set the number of BUSY cycles per divide (legal range 1..15).
REQ-003 Clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-004 Rst  input  1  SHALL be the reset: synchronous, active-low, sampled on rising Clk.
REQ-005 req  input  N_REQ  SHALL carry one divide request per requester, level-sensitive.
REQ-006 dividend  input  N_REQ*32  SHALL carry a signed 32-bit dividend per requester; requester i uses bits [32i+31:32i].
REQ-007 divisor  input  N_REQ*8  SHALL carry a signed 8-bit divisor per requester; requester i uses bits [8i+7:8i].
REQ-008 gnt  output  N_REQ  SHALL be a one-hot, one-cycle grant pulse.
REQ-009 done  output  N_REQ  SHALL be a one-hot, one-cycle completion pulse.
REQ-010 quot  output  8  SHALL be the signed result, shared by all requesters and valid while any done bit is high.
REQ-011 dz  output  1  SHALL flag divide-by-zero and be valid while any done bit is high.
REQ-012 busy  output  1  SHALL be high whenever the state is not IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-014 IDLE, req==0: the FSM SHALL stay in IDLE and all outputs SHALL hold.
REQ-015 IDLE, req!=0 at edge E: the winner w SHALL be chosen round-robin, searching upward from pointer ptr and wrapping at N_REQ.
REQ-016 At that same edge E, the arbiter SHALL latch dividend[w] and divisor[w], load cnt=LAT-1, enter BUSY and drive gnt=1<<w for the following cycle only.
REQ-017 After granting w, ptr SHALL become (w+1) mod N_REQ.
REQ-018 BUSY with cnt!=0: cnt SHALL decrement by 1.
REQ-019 BUSY with cnt==0: the arbiter SHALL register quot and dz, enter DONE, and drive done=1<<w for the following cycle only.
REQ-020 DONE SHALL always return to IDLE on the next edge, so the earliest next grant is at edge E+LAT+2 and throughput is one divide per LAT+2 cycles.
REQ-021 Arithmetic: a full signed 32/8 division SHALL be computed, truncating toward zero; quot SHALL be the low 8 bits of the 32-bit quotient, with overflow wrapping silently.
REQ-022 Divisor==0: quot SHALL be 0 and dz SHALL be 1; otherwise dz SHALL be 0.
REQ-023 Operands SHALL be captured only at the grant edge; later changes to dividend, divisor or req SHALL NOT affect the operation in flight.
REQ-024 Deasserting req[w] during BUSY SHALL NOT abort the operation; done[w] SHALL still pulse.
REQ-025 Requests arriving during BUSY or DONE SHALL NOT be granted until the FSM is back in IDLE, and SHALL NOT be lost while req stays high.
REQ-026 quot and dz SHALL hold their last values between done pulses.
REQ-027 Across any window in which all requesters hold req high, each requester SHALL receive exactly one grant per N_REQ grants.

Reset
REQ-028 While Rst==0 at an edge: state SHALL become IDLE, ptr=0, cnt=0, gnt=0, done=0, quot=0, dz=0, busy=0.
REQ-029 Reset asserted during BUSY or DONE SHALL abort the operation with no done pulse issued afterwards.
REQ-030 After reset releases, a pending req SHALL be grantable at the first edge sampled with Rst==1.

Verification
REQ-031 Single request: N_REQ=4, LAT=3; req=0001, dividend0=100, divisor0=8 -> gnt=0001 one cycle after edge E; done=0001 after E+3 with quot=12, dz=0; busy low after E+4.
REQ-032 Signed/truncation: dividend=-100, divisor=8 -> quot=-12 (8'hF4); dividend=1000, divisor=1 -> quot=8'hE8 (wrap).
REQ-033 Divide-by-zero: dividend=55, divisor=0 -> quot=0, dz=1 coincident with done.
REQ-034 Round-robin: req=1111 held for 8 operations -> grant order 0,1,2,3,0,1,2,3; grants spaced exactly 5 cycles apart.
REQ-035 Operand stability: after gnt=0010, change dividend1 and drop req[1] -> done=0010 still pulses with the originally latched result.
REQ-036 Reset mid-op: Rst=0 one cycle into BUSY -> no done pulse, all outputs 0; after release with req=0100, the first grant is gnt=0100 (ptr=0 search finds 2).
